stv_stream_packer: RTL

- Width up-converter that sits directly upstream of the team's synchronous FIFO.
- Accepts narrow ready/valid beats and packs RATIO beats into one wide word, first beat in the lowest lane.
- A wlast beat flushes a partial word early, tagged with its valid-lane count.
- The output port connects straight to the FIFO write side; wide words plus sideband are carried as the FIFO's data type.

---
 rtl/stv_stream_pkg.sv | 21 ++
 rtl/stv_stream_packer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stv_stream_pkg.sv
// Shared types and helpers for stv_stream_packer.
// lane_cnt_width : width of the valid-lane count field for a given ratio.
// stv_word_t     : payload template {data, count, last} for the downstream
//                  FIFO DTYPE. The FIFO is not parameterised per use, so the
//                  template is sized for the default 8-bit x 4 configuration.
package stv_stream_pkg;

   function automatic int unsigned lane_cnt_width(input int unsigned ratio);
      return $clog2(ratio) + 1;
   endfunction

   localparam int unsigned PKG_IN_WIDTH = 8;
   localparam int unsigned PKG_RATIO    = 4;

   typedef struct packed {
      logic [PKG_IN_WIDTH*PKG_RATIO-1:0]       data;
      logic [lane_cnt_width(PKG_RATIO)-1:0]    count;
      logic                                    last;
   } stv_word_t;

endpackage

// File: rtl/stv_stream_packer.sv
// stv_stream_packer: packs RATIO narrow ready/valid beats into one wide word,
// first beat in lane 0. wlast flushes a partial word with its lane count.
// Ports:
//   clk, arst_n             clock, asynchronous active-low reset
//   wvalid/wready/wdata/wlast  narrow input beat handshake
//   rvalid/rready           packed word handshake (to FIFO write side)
//   rdata                   packed word, lane k = rdata[k*IN_WIDTH +: IN_WIDTH]
//   rcount                  number of valid lanes (1..RATIO)
//   rlast                   word closes a packet
// Optional: define STV_STREAM_PACKER_TIMEOUT_EN to auto-flush a partial word
// after TIMEOUT idle cycles.
module stv_stream_packer
   import stv_stream_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned RATIO    = 4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                                   clk,
   input  logic                                   arst_n,
   input  logic                                   wvalid,
   output logic                                   wready,
   input  logic [IN_WIDTH-1:0]                    wdata,
   input  logic                                   wlast,
   output logic                                   rvalid,
   input  logic                                   rready,
   output logic [IN_WIDTH*RATIO-1:0]              rdata,
   output logic [lane_cnt_width(RATIO)-1:0]       rcount,
   output logic                                   rlast
);

   localparam int unsigned CNTWIDTH  = lane_cnt_width(RATIO);
   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

   // Elaboration-time parameter sanity checks.
   if (IN_WIDTH < 1) begin : g_bad_in_width
      $error("stv_stream_packer: IN_WIDTH must be >= 1");
   end
   if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $error("stv_stream_packer: RATIO must be a power of 2 and >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("stv_stream_packer: TIMEOUT must be >= 1");
   end

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [CNTWIDTH-1:0]    lc_q, lc_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic [CNTWIDTH-1:0]    cnt_q, cnt_d;
   logic                   last_q, last_d;
   logic                   accept_c;
   logic                   timeout_hit_c;
   logic [OUT_WIDTH-1:0]   word_c;

   assign rvalid   = (state_q == HOLD);
   assign wready   = !rvalid || rready;
   assign accept_c = wvalid && wready;
   assign rdata    = data_q;
   assign rcount   = cnt_q;
   assign rlast    = last_q;

`ifdef STV_STREAM_PACKER_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_q;

   // Idle cycles on a partially filled word; the flush fires on the
   // TIMEOUT-th idle cycle unless a beat is accepted in it.
   assign timeout_hit_c = (state_q == FILL) && (lc_q != '0) && !accept_c &&
                          (idle_q == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         idle_q <= '0;
      end else if (accept_c || state_q != FILL || lc_q == '0 || timeout_hit_c) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + IDLE_W'(1);
      end
   end
`else
   assign timeout_hit_c = 1'b0;
`endif

   // State, lane counter and word registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= FILL;
         lc_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lc_q    <= lc_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Next-state and word assembly.
   always_comb begin
      state_d = state_q;
      lc_d    = lc_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      word_c  = data_q;

      case (state_q)
         FILL: begin
            if (accept_c) begin
               // A fresh word starts zeroed so unused lanes read as 0.
               word_c = (lc_q == '0) ? '0 : data_q;
               for (int k = 0; k < int'(RATIO); k++) begin
                  if (CNTWIDTH'(k) == lc_q) begin
                     word_c[k*IN_WIDTH +: IN_WIDTH] = wdata;
                  end
               end
               data_d = word_c;
               if (lc_q == CNTWIDTH'(RATIO - 1) || wlast) begin
                  state_d = HOLD;
                  cnt_d   = lc_q + CNTWIDTH'(1);
                  last_d  = wlast;
                  lc_d    = '0;
               end else begin
                  lc_d    = lc_q + CNTWIDTH'(1);
               end
            end else if (timeout_hit_c) begin
               state_d = HOLD;
               cnt_d   = lc_q;
               last_d  = 1'b0;
               lc_d    = '0;
            end
         end
         HOLD: begin
            if (rready) begin
               if (accept_c) begin
                  // Beat lands in lane 0 of a fresh word while the old one leaves.
                  data_d = OUT_WIDTH'(wdata);
                  if (wlast) begin
                     cnt_d  = CNTWIDTH'(1);
                     last_d = 1'b1;
                     lc_d   = '0;
                  end else begin
                     state_d = FILL;
                     lc_d    = CNTWIDTH'(1);
                  end
               end else begin
                  state_d = FILL;
                  lc_d    = '0;
               end
            end
         end
         default: begin
            state_d = FILL;
            lc_d    = '0;
         end
      endcase
   end

endmodule
